// File: rtl/rr_resource_arbiter_pkg.sv
// rtl/rr_resource_arbiter_pkg.sv - shared FSM states, width helpers and defaults for the arbiter
package rr_resource_arbiter_pkg;

  localparam int TIMEOUT_DEFAULT = 15;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_GRANT   = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // A single requester still needs a 1-bit index port.
  function automatic int idx_width(input int n_req);
    return (n_req <= 2) ? 1 : clog2(n_req);
  endfunction

  // Counter must be able to hold the saturation value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return (clog2(timeout + 1) < 1) ? 1 : clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_resource_arbiter_pick.sv
// rtl/rr_resource_arbiter_pick.sv - round-robin pick: rotate past last owner, priority encode, un-rotate
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDXW  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  last,
  output logic             valid,
  output logic [IDXW-1:0]  sel
);

  logic [N_REQ-1:0] rot;
  int               base;
  int               pos;

  always_comb begin
    base  = (int'(last) + 1) % N_REQ;
    rot   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[(base + i) % N_REQ];
    end
    // Scan downward so the lowest rotated position (closest after last) wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        pos   = i;
      end
    end
    sel = IDXW'((base + pos) % N_REQ);
  end

endmodule

// File: rtl/rr_resource_arbiter.sv
// rtl/rr_resource_arbiter.sv - round-robin owner arbiter with done/drop/budget release and turnaround cycle
module rr_resource_arbiter
  import rr_resource_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  localparam int IDXW   = idx_width(N_REQ)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [N_REQ-1:0] req_in,
  input  logic             done_in,
  output logic [N_REQ-1:0] grant_out,
  output logic [IDXW-1:0]  grant_idx_out,
  output logic             busy_out,
  output logic             timeout_out
);

  localparam int CNTW = cnt_width(TIMEOUT);

  state_t          state;
  logic [CNTW-1:0] hold_cnt;
  logic [IDXW-1:0] last;
  logic            pick_valid;
  logic [IDXW-1:0] pick_sel;
  logic            owner_req;
  logic            budget_hit;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_pick (
    .req   (req_in),
    .last  (last),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  assign owner_req  = req_in[grant_idx_out];
  assign budget_hit = (hold_cnt == CNTW'(TIMEOUT - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      grant_out     <= '0;
      grant_idx_out <= '0;
      busy_out      <= 1'b0;
      timeout_out   <= 1'b0;
      hold_cnt      <= '0;
      last          <= IDXW'(N_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          timeout_out <= 1'b0;
          grant_out   <= '0;
          if (pick_valid) begin
            grant_out     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_sel;
            grant_idx_out <= pick_sel;
            busy_out      <= 1'b1;
            hold_cnt      <= '0;
            state         <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (done_in || !owner_req || budget_hit) begin
            grant_out   <= '0;
            busy_out    <= 1'b0;
            last        <= grant_idx_out;
            // Pulse only when the budget is the deciding cause.
            timeout_out <= !done_in && owner_req && budget_hit;
            state       <= ST_RELEASE;
          end else if (hold_cnt != CNTW'(TIMEOUT)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          timeout_out <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          grant_out   <= '0;
          busy_out    <= 1'b0;
          timeout_out <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb/tb_rr_resource_arbiter.sv - directed vector table plus corner sequences for rr_resource_arbiter
module tb_rr_resource_arbiter;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [3:0] req_in = '0;
  logic       done_in = 1'b0;
  logic [3:0] grant_out;
  logic [1:0] grant_idx_out;
  logic       busy_out;
  logic       timeout_out;

  int n_checks = 0;
  int n_pass   = 0;

  rr_resource_arbiter #(
    .N_REQ   (4),
    .TIMEOUT (15)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_in        (req_in),
    .done_in       (done_in),
    .grant_out     (grant_out),
    .grant_idx_out (grant_idx_out),
    .busy_out      (busy_out),
    .timeout_out   (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] idx;
    logic       b;
    logic       t;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst, input logic [3:0] req, input logic done,
                             input logic [3:0] g, input logic [1:0] idx,
                             input logic b, input logic t);
    vec_t r;
    r.rst = rst; r.req = req; r.done = done;
    r.g = g; r.idx = idx; r.b = b; r.t = t;
    return r;
  endfunction

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", name, tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_all(input string name, input int tag, input logic [3:0] g,
                         input logic [1:0] idx, input logic b, input logic t);
    chk({name, ".grant"}, tag, 32'(grant_out), 32'(g));
    chk({name, ".idx"}, tag, 32'(grant_idx_out), 32'(idx));
    chk({name, ".busy"}, tag, 32'(busy_out), 32'(b));
    chk({name, ".timeout"}, tag, 32'(timeout_out), 32'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi_cycles;
    int to_pulses;

    // Single requester: four grant cycles, done, release, regrant.
    vecs.push_back(v(1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(v(0, 4'b0010, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(0, 4'b0010, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(0, 4'b0010, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(0, 4'b0010, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(0, 4'b0010, 1, 4'b0000, 1, 0, 0));
    vecs.push_back(v(0, 4'b0010, 0, 4'b0000, 1, 0, 0));
    vecs.push_back(v(0, 4'b0010, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(0, 4'b0010, 1, 4'b0000, 1, 0, 0));
    // Rotation with all requests held: 0,1,2,3,0 with a 2-cycle gap.
    vecs.push_back(v(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(v(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(v(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(v(0, 4'b1111, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(v(0, 4'b1111, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(0, 4'b1111, 1, 4'b0000, 1, 0, 0));
    vecs.push_back(v(0, 4'b1111, 0, 4'b0000, 1, 0, 0));
    vecs.push_back(v(0, 4'b1111, 0, 4'b0100, 2, 1, 0));
    vecs.push_back(v(0, 4'b1111, 1, 4'b0000, 2, 0, 0));
    vecs.push_back(v(0, 4'b1111, 0, 4'b0000, 2, 0, 0));
    vecs.push_back(v(0, 4'b1111, 0, 4'b1000, 3, 1, 0));
    vecs.push_back(v(0, 4'b1111, 1, 4'b0000, 3, 0, 0));
    vecs.push_back(v(0, 4'b1111, 0, 4'b0000, 3, 0, 0));
    vecs.push_back(v(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(v(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
    // Request drop by owner 2 while 1 and 3 wait: next 3, then 1.
    vecs.push_back(v(1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(v(0, 4'b0100, 0, 4'b0100, 2, 1, 0));
    vecs.push_back(v(0, 4'b1010, 0, 4'b0000, 2, 0, 0));
    vecs.push_back(v(0, 4'b1010, 0, 4'b0000, 2, 0, 0));
    vecs.push_back(v(0, 4'b1010, 0, 4'b1000, 3, 1, 0));
    vecs.push_back(v(0, 4'b1010, 1, 4'b0000, 3, 0, 0));
    vecs.push_back(v(0, 4'b1010, 0, 4'b0000, 3, 0, 0));
    vecs.push_back(v(0, 4'b1010, 0, 4'b0010, 1, 1, 0));

    step();
    step();
    for (int i = 0; i < vecs.size(); i++) begin
      rst_in  = vecs[i].rst;
      req_in  = vecs[i].req;
      done_in = vecs[i].done;
      step();
      rst_in = 1'b0;
      chk_all("vec", i, vecs[i].g, vecs[i].idx, vecs[i].b, vecs[i].t);
    end

    // Asynchronous reset in the middle of a grant to requester 2.
    rst_in = 1'b1; req_in = 4'b0100; done_in = 1'b0;
    step();
    rst_in = 1'b0;
    step();
    chk("midrst.pre_grant", 0, 32'(grant_out), 32'(4'b0100));
    rst_in = 1'b1;
    #1;
    chk_all("midrst.async", 0, 4'b0000, 0, 0, 0);
    req_in = 4'b1111;
    step();
    rst_in = 1'b0;
    step();
    chk_all("midrst.first", 0, 4'b0001, 0, 1, 0);

    // Budget expiry with a single held request.
    rst_in = 1'b1; req_in = 4'b0001; done_in = 1'b0;
    step();
    rst_in = 1'b0;
    hi_cycles = 0;
    to_pulses = 0;
    step();
    for (int i = 0; i < 40 && grant_out != 4'b0000; i++) begin
      hi_cycles++;
      step();
    end
    chk("timeout.hold_cycles", 0, 32'(hi_cycles), 32'd15);
    chk("timeout.pulse", 0, 32'(timeout_out), 32'd1);
    chk("timeout.grant_in_release", 0, 32'(grant_out), 32'd0);
    chk("timeout.busy_in_release", 0, 32'(busy_out), 32'd0);
    if (timeout_out) to_pulses++;
    step();
    if (timeout_out) to_pulses++;
    chk("timeout.pulse_width", 0, 32'(to_pulses), 32'd1);
    chk("timeout.idle_grant", 0, 32'(grant_out), 32'd0);

    // done_in on the final budget cycle suppresses the timeout pulse.
    rst_in = 1'b1; req_in = 4'b0001; done_in = 1'b0;
    step();
    rst_in = 1'b0;
    step();
    for (int i = 0; i < 14; i++) step();
    chk("collide.still_granted", 0, 32'(grant_out), 32'(4'b0001));
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    chk("collide.grant", 0, 32'(grant_out), 32'd0);
    chk("collide.timeout", 0, 32'(timeout_out), 32'd0);
    step();
    chk("collide.timeout_next", 0, 32'(timeout_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  always @(negedge clk_in) begin
    if (!rst_in && ((grant_out & (grant_out - 4'd1)) != 4'b0000)) begin
      n_checks++;
      $display("FAIL onehot: got %b expected at most one bit", grant_out);
    end
  end

endmodule
